// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared definitions for the sequence-detector scan controller.
//   - state_e     : controller FSM states
//   - DEF_*       : default parameter values
//   - hits_width(): width of the per-word hit counter (holds 0..W)
package seq_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned DEF_W       = 8;
   localparam int unsigned DEF_DET_LAT = 1;
   localparam int unsigned DEF_TW      = 16;

   function automatic int unsigned hits_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/seq_scan_ctrl_piso.sv
// seq_piso: W-bit parallel-load, left-shift register with a bit counter.
// Ports:
//   clk, rst  : clock, async active-low reset
//   load      : capture din, clear bit counter (wins over shift)
//   shift     : shift left by one, advance bit counter
//   din       : parallel word
//   msb       : current serial bit (register MSB)
//   last      : the bit on msb is the final bit of the word
module seq_piso #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb,
   output logic         last
);

   localparam int unsigned CW = $clog2(W);

   logic [W-1:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign msb  = sr_q[W-1];
   assign last = (cnt_q == CW'(W - 1));

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (load) begin
         sr_d  = din;
         cnt_d = '0;
      end else if (shift) begin
         sr_d  = {sr_q[W-2:0], 1'b0};
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts W-bit words (valid/ready), shifts each MSB-first
// into a serial sequence detector, counts the detector hits belonging to
// that word and reports a per-word count plus a running total.
// Ports:
//   clk, rst              : clock, async active-low reset
//   in_valid/in_ready     : word handshake, in_data sampled at accept
//   det_w, det_rst, det_z : detector serial bit, detector reset, detector output
//   out_valid/out_ready   : per-word result handshake, out_hits = hits of word
//   total_hits            : accumulated hits, cleared by clr (clr has priority)
//   busy                  : controller not in IDLE
// Build option: define SEQ_SCAN_SAT_EN to make total_hits saturate instead
// of wrapping.
module seq_scan_ctrl
   import seq_scan_pkg::*;
#(
   parameter int unsigned W       = DEF_W,
   parameter int unsigned DET_LAT = DEF_DET_LAT,
   parameter int unsigned TW      = DEF_TW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [W-1:0]              in_data,
   output logic                      det_w,
   output logic                      det_rst,
   input  logic                      det_z,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [hits_width(W)-1:0]  out_hits,
   output logic [TW-1:0]             total_hits,
   input  logic                      clr,
   output logic                      busy
);

   localparam int unsigned HW = hits_width(W);
   localparam int unsigned DW = $clog2(DET_LAT + 1);

   state_e              state_q, state_d;
   logic [HW-1:0]       out_hits_q, out_hits_d;
   logic [TW-1:0]       total_q, total_d;
   logic [DET_LAT-1:0]  drv_pipe_q, drv_pipe_d;
   logic [DW-1:0]       dcnt_q, dcnt_d;

   logic accept, piso_msb, piso_last, hit;

   // Outputs decode only registered state, never inputs.
   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = (state_q == DONE);
   // Detector is held in reset between words so no history carries over.
   assign det_rst    = (state_q == IDLE) || (state_q == DONE);
   assign det_w      = (state_q == SHIFT) && piso_msb;
   assign out_hits   = out_hits_q;
   assign total_hits = total_q;

   assign accept = in_valid && in_ready;
   // A sample counts only when the bit that caused it was driven in SHIFT
   // exactly DET_LAT cycles earlier.
   assign hit    = drv_pipe_q[DET_LAT-1] && det_z;

   seq_piso #(.W(W)) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (state_q == SHIFT),
      .din   (in_data),
      .msb   (piso_msb),
      .last  (piso_last)
   );

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      unique case (state_q)
         IDLE:  if (accept) state_d = SHIFT;
         SHIFT: if (piso_last) begin
                   state_d = DRAIN;
                   dcnt_d  = '0;
                end
         DRAIN: if (dcnt_q == DW'(DET_LAT - 1)) state_d = DONE;
                else dcnt_d = dcnt_q + 1'b1;
         DONE:  if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      drv_pipe_d[0] = (state_q == SHIFT);
      for (int i = 1; i < DET_LAT; i++) drv_pipe_d[i] = drv_pipe_q[i-1];
   end

   always_comb begin
      out_hits_d = out_hits_q;
      if (accept) out_hits_d = '0;
      else if (hit && (out_hits_q != HW'(W))) out_hits_d = out_hits_q + 1'b1;
   end

`ifdef SEQ_SCAN_SAT_EN
   logic [TW:0] sum;
   always_comb begin
      sum     = {1'b0, total_q} + (TW+1)'(out_hits_q);
      total_d = total_q;
      if (clr) total_d = '0;
      else if ((state_q == DONE) && out_ready) total_d = sum[TW] ? '1 : sum[TW-1:0];
   end
`else
   always_comb begin
      total_d = total_q;
      if (clr) total_d = '0;
      else if ((state_q == DONE) && out_ready) total_d = total_q + TW'(out_hits_q);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         dcnt_q     <= '0;
         drv_pipe_q <= '0;
         out_hits_q <= '0;
         total_q    <= '0;
      end else begin
         state_q    <= state_d;
         dcnt_q     <= dcnt_d;
         drv_pipe_q <= drv_pipe_d;
         out_hits_q <= out_hits_d;
         total_q    <= total_d;
      end
   end

endmodule
